// File: rtl/dff_pkg.sv
// Shared constants and the transaction record for the dff_reg storage leaf.
package dff_pkg;
    localparam int MAX_STAGES = 16;
    localparam int MAX_WIDTH  = 32;
    localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] din;
        logic [MAX_WIDTH-1:0] dout;
    } dff_txn_t;
endpackage

// File: rtl/dff_if.sv
// Signal bundle for dff_reg; clock and reset ride along so the bench side sees them too.
interface dff_if #(
    parameter int WIDTH = 1
) (
    input logic clk,
    input logic rst_n
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    modport dut (input clk, input rst_n, input din, output dout);
    modport tb  (input clk, input rst_n, input dout, output din);
endinterface

// File: rtl/dff_stage.sv
// One WIDTH-bit register with asynchronous active-low reset.
module dff_stage #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RESET_VAL;
        else        q <= d;
    end
endmodule

// File: rtl/dff_reg.sv
// Cascade of STAGES identical registers; dout is din delayed by STAGES clock edges.
module dff_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input logic clk,
    input logic rst_n,
    dff_if.dut  bus
);
    if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1) begin : g_bad_param
        $error("dff_reg: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    // chain[0] is the input tap, chain[STAGES] the output of the last register
    logic [STAGES:0][WIDTH-1:0] chain;

    assign chain[0]  = bus.din;
    assign bus.dout  = chain[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

`ifndef SYNTHESIS
    // Bit k set once k+1 edges have passed with reset high; top bit means the pipe is primed.
    logic [STAGES-1:0] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= (vld_pipe << 1) | {{(STAGES-1){1'b0}}, 1'b1};
    end

    a_reset_hold: assert property (@(posedge clk) !rst_n |-> bus.dout == RESET_VAL);

    a_latency: assert property (@(posedge clk) disable iff (!rst_n)
        vld_pipe[STAGES-1] |-> bus.dout == $past(bus.din, STAGES));
`endif
endmodule

// File: tb/tb_dff_reg.sv
// Checks a default 1-bit DFF and an 8-bit 3-stage pipeline: reset, streams, async reset, flush.
module tb_dff_reg;
    import dff_pkg::*;

    localparam logic [7:0] RV_B = 8'h5A;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #10 clk = ~clk;

    dff_if #(.WIDTH(1)) if_a (.clk(clk), .rst_n(rst_a));
    dff_if #(.WIDTH(8)) if_b (.clk(clk), .rst_n(rst_b));

    dff_reg dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (if_a.dut)
    );

    dff_reg #(.WIDTH(8), .STAGES(3), .RESET_VAL(RV_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (if_b.dut)
    );

    typedef struct {
        logic rst_n;
        logic din;
        logic exp;
    } vec_t;

    vec_t     vecs [10];
    dff_txn_t sb_q [$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    initial begin
        dff_txn_t   t;
        logic       prev_exp;
        logic [7:0] stream_b [8];

        if_a.din = 1'b1;
        if_b.din = 8'h99;
        #1 rst_a = 1'b0;
        rst_b = 1'b0;
        #1 check("reset_a_initial", {7'b0, if_a.dout}, 8'h00);
        check("reset_b_initial", if_b.dout, RV_B);

        // reset hold with din=1, release, then toggle 0,1,0,1
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b1};

        prev_exp = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst_a    = vecs[i].rst_n;
            if_a.din = vecs[i].din;
            #1 check($sformatf("vec%0d_pre_edge", i), {7'b0, if_a.dout}, {7'b0, prev_exp});
            @(posedge clk);
            #1 check($sformatf("vec%0d_post_edge", i), {7'b0, if_a.dout}, {7'b0, vecs[i].exp});
            prev_exp = vecs[i].exp;
        end

        // random stream through the scoreboard, latency one edge
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                t = sb_q.pop_front();
                check($sformatf("stream%0d", i), {7'b0, if_a.dout}, t.dout[7:0]);
            end
            if (i < 30) begin
                if_a.din = 1'($urandom_range(0, 1));
                t.din    = '0;
                t.din[0] = if_a.din;
                t.dout   = t.din;
                sb_q.push_back(t);
            end
        end

        // async reset 5 units after an edge, with dout=1
        @(negedge clk);
        if_a.din = 1'b1;
        @(posedge clk);
        #1 check("async_pre", {7'b0, if_a.dout}, 8'h01);
        #4 rst_a = 1'b0;
        #1 check("async_immediate", {7'b0, if_a.dout}, 8'h00);
        @(negedge clk);
        check("async_before_next_edge", {7'b0, if_a.dout}, 8'h00);
        @(posedge clk);
        #1 check("async_hold", {7'b0, if_a.dout}, 8'h00);
        @(negedge clk);
        rst_a = 1'b1;

        // pipeline: A5, 3C, FF appear on edges 3, 4, 5 after release
        stream_b = '{8'hA5, 8'h3C, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_b.din = stream_b[i];
            t.din    = '0;
            t.din[7:0] = stream_b[i];
            t.dout   = t.din;
            sb_q.push_back(t);
            @(posedge clk);
            #1;
            if (i < 2) check($sformatf("pipe_fill%0d", i), if_b.dout, RV_B);
            else begin
                t = sb_q.pop_front();
                check($sformatf("pipe_edge%0d", i + 1), if_b.dout, t.dout[7:0]);
            end
            @(negedge clk);
        end
        // 11 and 22 still in flight; a one-cycle reset pulse must flush them
        sb_q.delete();
        if_b.din = 8'h66;
        rst_b    = 1'b0;
        #1 check("flush_immediate", if_b.dout, RV_B);
        @(negedge clk);
        rst_b    = 1'b1;
        if_b.din = 8'h77;
        #1 check("flush_release", if_b.dout, RV_B);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check($sformatf("flush_hold%0d", i), if_b.dout, RV_B);
            @(negedge clk);
            if_b.din = 8'h88;
        end
        @(posedge clk);
        #1 check("flush_first_data", if_b.dout, 8'h77);
        @(posedge clk);
        #1 check("flush_second_data", if_b.dout, 8'h88);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
